// File: rtl/game_result_arbiter.sv
// game_result_arbiter: round-robin share of one result path among roulette, even/odd and dice engines.
// Define DICE_PRIORITY_EN to let dice requests always win arbitration.
module game_result_arbiter #(
  parameter int DATA_W      = 5,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 26
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [2:0]        i_req,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic [DATA_W-1:0] i_eo_data,
  input  logic [DATA_W-1:0] i_dice_data,
  input  logic              i_release_hold,
  output logic [2:0]        o_grant,
  output logic [1:0]        o_select,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} state_t;
  localparam int HC = HOLD_CYCLES < 1 ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(HC - 1);
  state_t            r_state, w_state;
  logic [2:0]        r_grant, w_grant;
  logic [1:0]        r_select, w_select, r_last, w_last, r_win, w_win;
  logic [DATA_W-1:0] r_result, w_result;
  logic              r_valid, w_valid, r_busy, w_busy;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [2:0]        w_req;
  logic [1:0]        w_c0, w_c1, w_pick;
`ifdef DICE_PRIORITY_EN
  assign w_req = i_req[2] ? 3'b100 : i_req;
`else
  assign w_req = i_req;
`endif
  // search order starts just after the previous winner and ends on it
  assign w_c0   = r_last == 2'd2 ? 2'd0 : r_last + 2'd1;
  assign w_c1   = w_c0 == 2'd2 ? 2'd0 : w_c0 + 2'd1;
  assign w_pick = w_req[w_c0] ? w_c0 : w_req[w_c1] ? w_c1 : r_last;
  always_comb begin
    w_state  = r_state;
    w_grant  = r_grant;
    w_select = r_select;
    w_result = r_result;
    w_valid  = r_valid;
    w_busy   = r_busy;
    w_cnt    = r_cnt;
    w_last   = r_last;
    w_win    = r_win;
    case (r_state)
      S_IDLE: if (|w_req) begin
        w_state  = S_CAPTURE;
        w_win    = w_pick;
        w_grant  = 3'b001 << w_pick;
        w_select = w_pick;
        w_busy   = 1'b1;
      end
      S_CAPTURE: begin
        w_result = r_win == 2'd0 ? i_reg_data : r_win == 2'd1 ? i_eo_data : i_dice_data;
        w_cnt    = LOAD;
        w_valid  = 1'b1;
        w_state  = S_HOLD;
      end
      S_HOLD: begin
        w_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == '0 || i_release_hold) begin
          w_cnt    = '0;
          w_grant  = 3'b000;
          w_select = 2'b11;
          w_valid  = 1'b0;
          w_busy   = 1'b0;
          w_last   = r_win;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_grant  <= 3'b000;
      r_select <= 2'b11;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_last   <= 2'd2;
      r_win    <= 2'd0;
    end else begin
      r_state  <= w_state;
      r_grant  <= w_grant;
      r_select <= w_select;
      r_result <= w_result;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
      r_cnt    <= w_cnt;
      r_last   <= w_last;
      r_win    <= w_win;
    end
  end
  assign o_grant        = r_grant;
  assign o_select       = r_select;
  assign o_result       = r_result;
  assign o_result_valid = r_valid;
  assign o_busy         = r_busy;
endmodule

// File: tb/tb_game_result_arbiter.sv
// tb_game_result_arbiter: directed checks of arbitration order, hold timing, early release and reset.
module tb_game_result_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [4:0] reg_data, eo_data, dice_data;
  logic       rel;
  logic [2:0] g4, g0;
  logic [1:0] s4, s0;
  logic [4:0] r4, r0;
  logic       v4, v0, b4, b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  game_result_arbiter #(.DATA_W(5), .HOLD_CYCLES(4), .CNT_W(26)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_reg_data(reg_data), .i_eo_data(eo_data),
    .i_dice_data(dice_data), .i_release_hold(rel), .o_grant(g4), .o_select(s4),
    .o_result(r4), .o_result_valid(v4), .o_busy(b4));
  game_result_arbiter #(.DATA_W(5), .HOLD_CYCLES(0), .CNT_W(26)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_reg_data(reg_data), .i_eo_data(eo_data),
    .i_dice_data(dice_data), .i_release_hold(rel), .o_grant(g0), .o_select(s0),
    .o_result(r0), .o_result_valid(v0), .o_busy(b0));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_idle4(input string tag);
    check({tag, "_grant"}, 32'(g4), 0);
    check({tag, "_select"}, 32'(s4), 3);
    check({tag, "_valid"}, 32'(v4), 0);
    check({tag, "_busy"}, 32'(b4), 0);
  endtask
  logic [2:0] exp_g [4];
  initial begin
    rst = 1'b1; req = 3'b000; reg_data = '0; eo_data = '0; dice_data = '0; rel = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    // 1: reset state
    check_idle4("rst");
    check("rst_result", 32'(r4), 0);
    check("rst0_select", 32'(s0), 3);
    // 2: single regular request held for four cycles
    req = 3'b001; reg_data = 5'd17;
    tick;
    check("t2_grant", 32'(g4), 1);
    check("t2_select", 32'(s4), 0);
    check("t2_busy", 32'(b4), 1);
    check("t2_valid_early", 32'(v4), 0);
    req = 3'b000;
    tick;
    check("t2_result", 32'(r4), 17);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_valid_hold%0d", i), 32'(v4), 1);
      tick;
    end
    check_idle4("t2_end");
    check("t2_result_kept", 32'(r4), 17);
    // 3: round-robin order from reset
    rst = 1'b1; #2 rst = 1'b0;
`ifdef DICE_PRIORITY_EN
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100};
`else
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("t3_grant%0d", i), 32'(g4), 32'(exp_g[i]));
      repeat (5) tick;
    end
    req = 3'b000;
    // 4: data change in hold ignored, early release
    tick;
    req = 3'b010; eo_data = 5'd5;
    tick;
    check("t4_grant", 32'(g4), 2);
    check("t4_select", 32'(s4), 1);
    req = 3'b000;
    tick;
    eo_data = 5'd9;
    check("t4_result", 32'(r4), 5);
    tick;
    rel = 1'b1;
    check("t4_valid_hold2", 32'(v4), 1);
    tick;
    rel = 1'b0;
    check_idle4("t4_rel");
    check("t4_result_kept", 32'(r4), 5);
    // 5: asynchronous reset during hold, then round-robin restarts at regular
    tick;
    req = 3'b100; dice_data = 5'd3;
    repeat (3) tick;
    req = 3'b000;
    check("t5_valid_before", 32'(v4), 1);
    #2 rst = 1'b1;
    #1;
    check_idle4("t5_async");
    check("t5_result", 32'(r4), 0);
    tick;
    #2 rst = 1'b0;
    req = 3'b111;
    tick;
    check("t5_grant", 32'(g4), 1);
    req = 3'b000;
    repeat (6) tick;
    // 6: HOLD_CYCLES=0 holds for one cycle
    req = 3'b100; dice_data = 5'd31;
    tick;
    check("t6_grant", 32'(g0), 4);
    check("t6_select", 32'(s0), 2);
    req = 3'b000;
    tick;
    check("t6_result", 32'(r0), 31);
    check("t6_valid", 32'(v0), 1);
    tick;
    check("t6_valid_end", 32'(v0), 0);
    check("t6_busy_end", 32'(b0), 0);
    check("t6_result_kept", 32'(r0), 31);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
